// File: rtl/core2wb_bridge.sv
// core2wb_bridge: Ibex req/gnt/rvalid memory port to a pipelined Wishbone B4 master.
// Define CORE2WB_RESP_REG_EN to register the response path (one extra cycle of latency).
module core2wb_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  output logic        core_gnt,
  input  logic        core_we,
  input  logic [3:0]  core_be,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  output logic        core_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_stall
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          busy;
  logic          resp;
  logic          rvalid_c;
  logic          err_c;

  assign busy     = (cnt != '0);
  assign wb_stb   = core_req & (cnt < MAX_CNT);
  assign core_gnt = wb_stb & ~wb_stall;
  assign wb_we    = core_we;
  assign wb_sel   = core_be;
  assign wb_adr   = core_addr;
  assign wb_dat_o = core_wdata;

  // Responses with nothing outstanding are stray and must not underflow cnt.
  assign resp     = (wb_ack | wb_err) & busy;
  assign rvalid_c = resp;
  assign err_c    = wb_err & rvalid_c;

  always_comb begin
    cnt_d = cnt;
    unique case ({core_gnt, resp})
      2'b10:   cnt_d = cnt + 1'b1;
      2'b01:   cnt_d = cnt - 1'b1;
      default: cnt_d = cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

`ifdef CORE2WB_RESP_REG_EN
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_c;
      err_q    <= err_c;
      rdata_q  <= wb_dat_i;
    end
  end

  // Hold the cycle open until the registered response has reached the core.
  assign wb_cyc      = wb_stb | busy | rvalid_q;
  assign core_rvalid = rvalid_q;
  assign core_err    = err_q;
  assign core_rdata  = rdata_q;
`else
  assign wb_cyc      = wb_stb | busy;
  assign core_rvalid = rvalid_c;
  assign core_err    = err_c;
  assign core_rdata  = wb_dat_i;
`endif

endmodule

// File: tb/tb_core2wb_bridge.sv
// tb_core2wb_bridge: vector table, reset sequence and randomized traffic
// against a scoreboard reference for core2wb_bridge.
module tb_core2wb_bridge;

  localparam int MAX = 2;
`ifdef CORE2WB_RESP_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req;
  logic        core_gnt;
  logic        core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_rvalid;
  logic [31:0] core_rdata;
  logic        core_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;

  core2wb_bridge #(.MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we),
    .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic        gnt;
    logic        stb;
    logic        cyc;
    logic        rv;
    logic        cerr;
  } vec_t;

  function automatic vec_t mkv(logic req, logic we, logic [31:0] addr,
                               logic [31:0] wdata, logic stall, logic ack,
                               logic err, logic [31:0] dat, logic gnt,
                               logic stb, logic cyc, logic rv, logic cerr);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
    v.stall = stall; v.ack = ack; v.err = err; v.dat = dat;
    v.gnt = gnt; v.stb = stb; v.cyc = cyc; v.rv = rv; v.cerr = cerr;
    return v;
  endfunction

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] data;
    int          rdy;
  } sl_t;

  exp_t        eq[$];
  sl_t         sq[$];
  logic [31:0] rmem[16];
  logic [31:0] smem[16];
  int          mcnt;
  int          cyc_n;
  logic        d_rv;
  exp_t        d_item;
  logic        s_resp;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  task automatic rcycle(input bit allow_req);
    logic e_stb, e_gnt, e_cyc, e_rv, now_rv, acc;
    exp_t item, cur;
    sl_t  s;
    logic [3:0] idx;
    @(posedge clk); #1;
    cyc_n++;
    core_req   = allow_req && ($urandom_range(0, 99) < 70);
    core_we    = 1'($urandom_range(0, 1));
    core_addr  = ($urandom_range(0, 9) == 0) ? 32'hFFFC
                 : {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    core_wdata = $urandom;
    core_be    = 4'($urandom_range(1, 15));
    wb_stall   = ($urandom_range(0, 3) == 0);
    s_resp     = 1'b0;
    wb_ack     = 1'b0;
    wb_err     = 1'b0;
    wb_dat_i   = $urandom;
    if (sq.size() > 0 && sq[0].rdy <= cyc_n) begin
      s_resp = 1'b1;
      wb_ack = ~sq[0].err;
      wb_err = sq[0].err;
      if (!sq[0].we) wb_dat_i = sq[0].data;
    end
    @(negedge clk);
    e_stb = core_req && (mcnt < MAX);
    e_gnt = e_stb && !wb_stall;
    e_cyc = e_stb || (mcnt != 0) || (REG && d_rv);
    chk("rnd_stb", 32'(wb_stb), 32'(e_stb));
    chk("rnd_gnt", 32'(core_gnt), 32'(e_gnt));
    chk("rnd_cyc", 32'(wb_cyc), 32'(e_cyc));
    now_rv = s_resp && (eq.size() > 0);
    item = '{we: 1'b1, err: 1'b0, data: 32'd0};
    if (now_rv) item = eq.pop_front();
    e_rv = REG ? d_rv : now_rv;
    cur  = REG ? d_item : item;
    chk("rnd_rvalid", 32'(core_rvalid), 32'(e_rv));
    if (e_rv) begin
      chk("rnd_err", 32'(core_err), 32'(cur.err));
      if (!cur.we && !cur.err) chk("rnd_rdata", core_rdata, cur.data);
    end
    if (e_gnt) begin
      idx = core_addr[5:2];
      item.we = core_we;
      item.err = (core_addr == 32'hFFFC);
      item.data = rmem[idx];
      if (core_we && !item.err) rmem[idx] = merge(rmem[idx], core_wdata, core_be);
      eq.push_back(item);
    end
    mcnt = mcnt + (e_gnt ? 1 : 0) - (now_rv ? 1 : 0);
    d_rv = now_rv;
    d_item = item;
    if (s_resp) void'(sq.pop_front());
    acc = wb_cyc && wb_stb && !wb_stall;
    if (acc) begin
      idx = wb_adr[5:2];
      s.we = wb_we;
      s.err = (wb_adr == 32'hFFFC);
      s.data = smem[idx];
      s.rdy = cyc_n + $urandom_range(1, 4);
      if (wb_we && !s.err) smem[idx] = merge(smem[idx], wb_dat_o, wb_sel);
      sq.push_back(s);
    end
  endtask

  vec_t tbl[22];

  initial begin
    logic p_rv, p_err, e_rv, e_err, e_cyc;
    logic [31:0] p_dat, e_dat;

    tbl[0]  = mkv(0, 0, 32'h0,    32'h0,        0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 0, 32'h0,    32'h0,        0, 1, 0, 32'h1111, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(1, 1, 32'h10,   32'hDEADBEEF, 0, 0, 0, 32'h0,    1, 1, 1, 0, 0);
    tbl[3]  = mkv(0, 0, 32'h0,    32'h0,        0, 1, 0, 32'h0,    0, 0, 1, 1, 0);
    tbl[4]  = mkv(0, 0, 32'h0,    32'h0,        0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    tbl[5]  = mkv(1, 0, 32'h0,    32'h0,        0, 0, 0, 32'h0,    1, 1, 1, 0, 0);
    tbl[6]  = mkv(1, 0, 32'h4,    32'h0,        0, 1, 0, 32'hA0,   1, 1, 1, 1, 0);
    tbl[7]  = mkv(1, 0, 32'h8,    32'h0,        0, 1, 0, 32'hA1,   1, 1, 1, 1, 0);
    tbl[8]  = mkv(1, 0, 32'hC,    32'h0,        0, 1, 0, 32'hA2,   1, 1, 1, 1, 0);
    tbl[9]  = mkv(0, 0, 32'h0,    32'h0,        0, 1, 0, 32'hA3,   0, 0, 1, 1, 0);
    tbl[10] = mkv(1, 0, 32'h20,   32'h0,        1, 0, 0, 32'h0,    0, 1, 1, 0, 0);
    tbl[11] = mkv(1, 0, 32'h20,   32'h0,        1, 0, 0, 32'h0,    0, 1, 1, 0, 0);
    tbl[12] = mkv(1, 0, 32'h20,   32'h0,        1, 0, 0, 32'h0,    0, 1, 1, 0, 0);
    tbl[13] = mkv(1, 0, 32'h20,   32'h0,        0, 0, 0, 32'h0,    1, 1, 1, 0, 0);
    tbl[14] = mkv(1, 0, 32'h24,   32'h0,        0, 0, 0, 32'h0,    1, 1, 1, 0, 0);
    tbl[15] = mkv(1, 0, 32'h28,   32'h0,        0, 0, 0, 32'h0,    0, 0, 1, 0, 0);
    tbl[16] = mkv(1, 0, 32'h28,   32'h0,        0, 1, 0, 32'hB0,   0, 0, 1, 1, 0);
    tbl[17] = mkv(1, 0, 32'h28,   32'h0,        0, 0, 0, 32'h0,    1, 1, 1, 0, 0);
    tbl[18] = mkv(0, 0, 32'hFFFC, 32'h0,        0, 0, 1, 32'hE0,   0, 0, 1, 1, 1);
    tbl[19] = mkv(0, 0, 32'h0,    32'h0,        0, 1, 0, 32'hB1,   0, 0, 1, 1, 0);
    tbl[20] = mkv(0, 0, 32'h0,    32'h0,        0, 0, 0, 32'h0,    0, 0, 0, 0, 0);
    tbl[21] = mkv(0, 0, 32'h0,    32'h0,        0, 0, 0, 32'h0,    0, 0, 0, 0, 0);

    rst = 1'b1;
    core_req = 0; core_we = 0; core_be = 4'hF; core_addr = '0; core_wdata = '0;
    wb_dat_i = '0; wb_ack = 0; wb_err = 0; wb_stall = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    p_rv = 0; p_err = 0; p_dat = '0;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      core_req = tbl[i].req; core_we = tbl[i].we; core_addr = tbl[i].addr;
      core_wdata = tbl[i].wdata; core_be = 4'hF; wb_stall = tbl[i].stall;
      wb_ack = tbl[i].ack; wb_err = tbl[i].err; wb_dat_i = tbl[i].dat;
      @(negedge clk);
      e_rv  = REG ? p_rv : tbl[i].rv;
      e_err = REG ? p_err : tbl[i].cerr;
      e_dat = REG ? p_dat : tbl[i].dat;
      e_cyc = tbl[i].cyc | (REG & p_rv);
      chk($sformatf("v%0d_gnt", i), 32'(core_gnt), 32'(tbl[i].gnt));
      chk($sformatf("v%0d_stb", i), 32'(wb_stb), 32'(tbl[i].stb));
      chk($sformatf("v%0d_cyc", i), 32'(wb_cyc), 32'(e_cyc));
      chk($sformatf("v%0d_rvalid", i), 32'(core_rvalid), 32'(e_rv));
      chk($sformatf("v%0d_err", i), 32'(core_err), 32'(e_err));
      chk($sformatf("v%0d_rdata", i), core_rdata, e_dat);
      chk($sformatf("v%0d_adr", i), wb_adr, tbl[i].addr);
      chk($sformatf("v%0d_dat_o", i), wb_dat_o, tbl[i].wdata);
      chk($sformatf("v%0d_we", i), 32'(wb_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_sel", i), 32'(wb_sel), 32'hF);
      p_rv = tbl[i].rv; p_err = tbl[i].cerr; p_dat = tbl[i].dat;
    end

    // Asynchronous reset with two requests outstanding, then a stray ack.
    @(posedge clk); #1;
    core_req = 1; core_we = 0; core_addr = 32'h30; wb_ack = 0; wb_err = 0;
    @(posedge clk); #1;
    core_addr = 32'h34;
    @(posedge clk); #1;
    core_req = 0;
    @(negedge clk);
    chk("pre_rst_cyc", 32'(wb_cyc), 32'd1);
    chk("pre_rst_stb_full", 32'(wb_stb), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_cyc", 32'(wb_cyc), 32'd0);
    chk("rst_rvalid", 32'(core_rvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    wb_ack = 1'b1;
    @(negedge clk);
    chk("stray_rvalid", 32'(core_rvalid), 32'd0);
    chk("stray_cyc", 32'(wb_cyc), 32'd0);
    @(posedge clk); #1;
    wb_ack = 1'b0;
    @(negedge clk);
    chk("stray_rvalid2", 32'(core_rvalid), 32'd0);
    chk("stray_cyc2", 32'(wb_cyc), 32'd0);
    core_req = 1'b1;
    #1;
    chk("post_stray_stb", 32'(wb_stb), 32'd1);
    core_req = 1'b0;

    for (int i = 0; i < 16; i++) begin
      rmem[i] = '0;
      smem[i] = '0;
    end
    mcnt = 0; cyc_n = 0; d_rv = 0;
    d_item = '{we: 1'b1, err: 1'b0, data: 32'd0};
    for (int c = 0; c < 400; c++) rcycle(1'b1);
    for (int c = 0; c < 40; c++) begin
      if (eq.size() == 0 && sq.size() == 0 && !d_rv) break;
      rcycle(1'b0);
    end
    chk("drain_exp_empty", 32'(eq.size()), 32'd0);
    chk("drain_slave_empty", 32'(sq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
